// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT input gearbox.
package ntt_pkg;

    localparam int unsigned DATA_WIDTH_PER_INPUT = 28;
    localparam int unsigned INPUT_PER_CYCLE      = 64;
    localparam int unsigned NTT_SIZE             = 2048;

    localparam int unsigned FRAMES_PER_POLY = NTT_SIZE / INPUT_PER_CYCLE;
    localparam int unsigned LANE_W          = $clog2(INPUT_PER_CYCLE);
    localparam int unsigned FRAME_W         = $clog2(FRAMES_PER_POLY);

    typedef logic [DATA_WIDTH_PER_INPUT-1:0] coeff_t;
    typedef coeff_t [INPUT_PER_CYCLE-1:0]    frame_t;

    localparam coeff_t DEFAULT_MODULUS = 28'd268361729;

    // Ping-pong bank selector
    typedef enum logic {
        BankA = 1'b0,
        BankB = 1'b1
    } bank_e;

    function automatic bank_e other_bank(bank_e b);
        return (b == BankA) ? BankB : BankA;
    endfunction

endpackage

// File: rtl/ntt_input_gearbox_if.sv
// Serial coefficient stream in, lane-parallel frame stream out.
interface ntt_input_gearbox_if
    import ntt_pkg::*;
();

    coeff_t s_data;
    logic   s_valid;
    logic   s_last;
    logic   s_ready;
    frame_t m_data;
    logic   m_valid;
    logic   m_ready;
    logic   m_start;

    // Environment side: produces coefficients, consumes frames
    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  m_start
    );

    // Gearbox side
    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready,
        output m_data,
        output m_valid,
        input  m_ready,
        output m_start
    );

endinterface

// File: rtl/ntt_gearbox_bank.sv
// One ping-pong bank: P-lane frame register, full flag and start-of-polynomial tag.
module ntt_gearbox_bank
    import ntt_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [LANE_W-1:0] wr_lane,
    input  coeff_t            wr_data,
    input  logic              wr_close,
    input  logic              wr_start,
    input  logic              rd_pop,
    output frame_t            data,
    output logic              full,
    output logic              start
);

    frame_t data_q;
    logic   full_q;
    logic   start_q;

    // Lane writes, close on last lane, release on pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            full_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            if (wr_en) begin
                data_q[wr_lane] <= wr_data;
            end
            // Close needs an empty bank and pop needs a full one, so they never coincide
            if (wr_close) begin
                full_q  <= 1'b1;
                start_q <= wr_start;
            end else if (rd_pop) begin
                full_q <= 1'b0;
            end
        end
    end

    assign data  = data_q;
    assign full  = full_q;
    assign start = start_q;

endmodule

// File: rtl/ntt_input_gearbox.sv
// Packs serial coefficients into P-lane frames through two ping-pong banks.
module ntt_input_gearbox
    import ntt_pkg::*;
#(
    parameter coeff_t MODULUS = DEFAULT_MODULUS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ntt_input_gearbox_if.slave        bus,
    output logic                      err_range,
    output logic                      err_framing
);

    logic [LANE_W-1:0]  lane_q;
    logic [FRAME_W-1:0] frame_q;
    bank_e              wr_bank_q;
    bank_e              rd_bank_q;
    logic               err_range_q;
    logic               err_framing_q;

    logic   accept;
    logic   pop;
    logic   last_lane;
    logic   last_index;
    logic   close;
    logic   [1:0] bank_wr_en;
    logic   [1:0] bank_close;
    logic   [1:0] bank_pop;
    logic   [1:0] bank_full;
    logic   [1:0] bank_start;
    frame_t bank_data [2];

    assign accept     = bus.s_valid & bus.s_ready;
    assign pop        = bus.m_valid & bus.m_ready;
    assign last_lane  = (lane_q == LANE_W'(INPUT_PER_CYCLE - 1));
    assign last_index = last_lane && (frame_q == FRAME_W'(FRAMES_PER_POLY - 1));
    assign close      = accept & last_lane;

    // Steer write/close to the write bank and pop to the read bank
    always_comb begin
        bank_wr_en = 2'b00;
        bank_close = 2'b00;
        bank_pop   = 2'b00;
        bank_wr_en[wr_bank_q] = accept;
        bank_close[wr_bank_q] = close;
        bank_pop[rd_bank_q]   = pop;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ntt_gearbox_bank u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (bank_wr_en[b]),
            .wr_lane  (lane_q),
            .wr_data  (bus.s_data),
            .wr_close (bank_close[b]),
            .wr_start (frame_q == '0),
            .rd_pop   (bank_pop[b]),
            .data     (bank_data[b]),
            .full     (bank_full[b]),
            .start    (bank_start[b])
        );
    end

    // Lane/frame counters and bank pointers; counters wrap after N-1 regardless of s_last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q    <= '0;
            frame_q   <= '0;
            wr_bank_q <= BankA;
            rd_bank_q <= BankA;
        end else begin
            if (accept) begin
                if (last_lane) begin
                    lane_q    <= '0;
                    wr_bank_q <= other_bank(wr_bank_q);
                    frame_q   <= last_index ? '0 : frame_q + FRAME_W'(1);
                end else begin
                    lane_q <= lane_q + LANE_W'(1);
                end
            end
            if (pop) begin
                rd_bank_q <= other_bank(rd_bank_q);
            end
        end
    end

    // Sticky input checks; out-of-range data is still stored unmodified
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_range_q   <= 1'b0;
            err_framing_q <= 1'b0;
        end else if (accept) begin
            if (bus.s_data >= MODULUS) begin
                err_range_q <= 1'b1;
            end
            if (bus.s_last != last_index) begin
                err_framing_q <= 1'b1;
            end
        end
    end

    assign bus.s_ready = !bank_full[wr_bank_q];
    assign bus.m_valid = bank_full[rd_bank_q];
    assign bus.m_data  = bank_data[rd_bank_q];
    assign bus.m_start = bank_full[rd_bank_q] & bank_start[rd_bank_q];
    assign err_range   = err_range_q;
    assign err_framing = err_framing_q;

endmodule
